ram_dual_arb: RTL and testbench
===============================

# ram_dual_arb

Two-requester arbiter and sequencer placed in front of one port of `ram_dual`, a synchronous-read RAM with a single-cycle read. It accepts read/write requests from requesters A and B over a req/gnt handshake and grants at most one per cycle. It drives the granted command to the RAM port through registers and routes the read data back to the requester that issued the read, qualified by a per-requester `rvalid` strobe.

## Interface
- `ADDR_W`, 8, RAM address width
- `DATA_W`, 8, RAM data width

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `a_req`  in  1  requester A command valid; held with fields until `a_gnt`
- `a_we`  in  1  A: 1 = write, 0 = read
- `a_addr`  in  ADDR_W  A address
- `a_wdata`  in  DATA_W  A write data
- `a_gnt`  out  1  A command accepted this cycle (combinational)
- `a_rvalid`  out  1  A read data valid (registered tag)
- `a_rdata`  out  DATA_W  A read data (passthrough of `ram_rdata`)
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: same as A, for requester B
- `ram_en`  out  1  RAM access strobe (registered)
- `ram_we`  out  1  RAM write enable (registered)
- `ram_addr`  out  ADDR_W  RAM address (registered)
- `ram_wdata`  out  DATA_W  RAM write data (registered)
- `ram_rdata`  in  DATA_W  RAM read data, valid one cycle after the `ram_en` read

## Operation
- Arbitration is combinational on each cycle's `a_req`/`b_req`. Exactly one `gnt` is high when any `req` is high; both are low when neither is.
- A grant is a completed handshake. The requester may change or drop its request on the next cycle. Requests are never queued.
- When only one requester is active, it is granted.
- When both are active: the requester not granted most recently wins (round-robin, see Configuration). The pointer `last` updates only on a grant.
- On a grant at edge n, the granted `we/addr/wdata` are registered onto the `ram_*` outputs and `ram_en=1` for cycle n+1. With no grant, `ram_en=0` and `ram_we=0`. `ram_addr` and `ram_wdata` hold their previous values.
- Read tag pipeline:
  - A granted read sets tag `{valid, owner}` in cycle n+1.
  - The tag advances one stage, so the owner's `rvalid=1` in cycle n+2, aligned with `ram_rdata`.
  - Writes never produce `rvalid`.
- `a_rdata` and `b_rdata` both equal `ram_rdata` at all times. Only `rvalid` qualifies them.
- Throughput is one access per cycle. Back-to-back reads from alternating owners each return in order with the correct owner's `rvalid`.
- State: `last` (1 bit) and the 2-stage tag pipeline (valid + owner per stage). No other FSM.

## Timing
- Reset (`rst_n` low, asynchronous):
  - `ram_en=0`, `ram_we=0`, `ram_addr=0`, `ram_wdata=0`
  - tag pipeline cleared, so `a_rvalid=b_rvalid=0`
  - `last`=B, so A wins the first tie
  - `a_gnt=b_gnt=0` while `rst_n` is low
- Reset asserted mid-read: in-flight tags are discarded and no `rvalid` appears after release. Requesters must re-issue.
- First grant is possible in the first cycle with `rst_n` high.
- Read latency: grant cycle n, then `rvalid` in cycle n+2.
- Write latency: grant cycle n, then RAM write at edge n+1→n+2.
- Same-cycle read after write to the same address by either requester: the RAM port sees the accesses in grant order. A read granted the cycle after a write returns the new data (RAM read-after-write across cycles).
- A request that drops in the same cycle it would have been granted is not granted and has no effect.

## Configuration
- `RAM_ARB_RR_EN` defined: round-robin on ties as described.
- Not defined: fixed priority, A always wins ties. `last` is not implemented, and B is granted only when `a_req=0`.

## Test plan
- Reset release, `a_req=1` read at `addr=0x10` (RAM preloaded with `0x5A`) → `a_gnt=1` cycle 0; `ram_en=1`, `ram_addr=0x10` cycle 1; `a_rvalid=1`, `a_rdata=0x5A` cycle 2; `b_rvalid=0` throughout.
- Both requesting continuously, A write and B read (with `RAM_ARB_RR_EN`) → grants alternate A,B,A,B starting with A; each B read yields `b_rvalid` two cycles after its `b_gnt`.
- Same as the previous test without `RAM_ARB_RR_EN` → `a_gnt` every cycle and `b_gnt` never; after `a_req` drops, `b_gnt=1` the same cycle.
- A writes `0x33` to `0x04`, then B reads `0x04` the next cycle → `b_rvalid=1`, `b_rdata=0x33` two cycles after `b_gnt`.
- A read granted, then `rst_n` pulsed low for one cycle at cycle 1 → `ram_en=0` immediately; no `a_rvalid` in any later cycle; `a_gnt=0` during reset.
- Idle (no `req`) for 5 cycles after traffic → `ram_en=0`, `ram_we=0`, no `rvalid`; `ram_addr` holds its last value.

Source files
------------

// File: rtl/ram_dual_arb.sv
// Two-requester arbiter/sequencer in front of one synchronous-read RAM port.
// Define RAM_ARB_RR_EN for round-robin tie-breaking; otherwise A has fixed priority.
module ram_dual_arb #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic              gnt_any;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              tag1_valid, tag1_owner;
    logic              tag2_valid, tag2_owner;

`ifdef RAM_ARB_RR_EN
    logic last;  // 1 = B was granted most recently

    always_comb begin
        a_gnt = rst_n & a_req & (~b_req | last);
        b_gnt = rst_n & b_req & (~a_req | ~last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (a_gnt) begin
            last <= 1'b0;
        end else if (b_gnt) begin
            last <= 1'b1;
        end
    end
`else
    always_comb begin
        a_gnt = rst_n & a_req;
        b_gnt = rst_n & b_req & ~a_req;
    end
`endif

    always_comb begin
        gnt_any   = a_gnt | b_gnt;
        sel_we    = b_gnt ? b_we    : a_we;
        sel_addr  = b_gnt ? b_addr  : a_addr;
        sel_wdata = b_gnt ? b_wdata : a_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_en <= gnt_any;
            ram_we <= gnt_any & sel_we;
            if (gnt_any) begin
                ram_addr  <= sel_addr;
                ram_wdata <= sel_wdata;
            end
        end
    end

    // Stage 2 lines up with ram_rdata, one cycle after the RAM sees the read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag1_valid <= 1'b0;
            tag1_owner <= 1'b0;
            tag2_valid <= 1'b0;
            tag2_owner <= 1'b0;
        end else begin
            tag1_valid <= gnt_any & ~sel_we;
            tag1_owner <= b_gnt;
            tag2_valid <= tag1_valid;
            tag2_owner <= tag1_owner;
        end
    end

    always_comb begin
        a_rvalid = tag2_valid & ~tag2_owner;
        b_rvalid = tag2_valid & tag2_owner;
        a_rdata  = ram_rdata;
        b_rdata  = ram_rdata;
    end

endmodule

// File: tb/tb_ram_dual_arb.sv
// Self-checking bench for ram_dual_arb: a RAM model drives ram_rdata, and a
// transaction-level model (shadow memory plus a read-return queue) predicts every output.
module tb_ram_dual_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_req, a_we, b_req, b_we;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    ram_dual_arb #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM behind the port: synchronous read, one-cycle latency
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    // Reference model state
    typedef struct {
        int       due;
        bit       owner;  // 0 = A, 1 = B
        bit [7:0] data;
    } rd_t;
    rd_t      rq[$];
    bit [7:0] shadow [256];
    bit       last_b;
    bit       exp_en, exp_we;
    bit [7:0] exp_addr, exp_wdata;

    task automatic model_reset();
        rq.delete();
        last_b    = 1'b1;
        exp_en    = 1'b0;
        exp_we    = 1'b0;
        exp_addr  = '0;
        exp_wdata = '0;
    endtask

    // One clock cycle: drive requests, check every output, advance the model.
    task automatic step(input bit ar, input bit aw, input bit [7:0] aa, input bit [7:0] ad,
                        input bit br, input bit bw, input bit [7:0] ba, input bit [7:0] bd);
        bit eg_a, eg_b, ev_a, ev_b;
        bit [7:0] ev_d;
        @(negedge clk);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        #1;
`ifdef RAM_ARB_RR_EN
        eg_a = ar && (!br || last_b);
`else
        eg_a = ar;
`endif
        eg_b = br && !eg_a;
        ev_a = 1'b0; ev_b = 1'b0; ev_d = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            ev_a = !rq[0].owner;
            ev_b = rq[0].owner;
            ev_d = rq[0].data;
            void'(rq.pop_front());
        end

        vectors++;
        if (a_gnt !== eg_a) begin miscompares++; $display("FAIL a_gnt cyc %0d: got %b expected %b", cyc, a_gnt, eg_a); end
        vectors++;
        if (b_gnt !== eg_b) begin miscompares++; $display("FAIL b_gnt cyc %0d: got %b expected %b", cyc, b_gnt, eg_b); end
        vectors++;
        if (ram_en !== exp_en) begin miscompares++; $display("FAIL ram_en cyc %0d: got %b expected %b", cyc, ram_en, exp_en); end
        vectors++;
        if (ram_we !== exp_we) begin miscompares++; $display("FAIL ram_we cyc %0d: got %b expected %b", cyc, ram_we, exp_we); end
        vectors++;
        if (ram_addr !== exp_addr) begin miscompares++; $display("FAIL ram_addr cyc %0d: got %h expected %h", cyc, ram_addr, exp_addr); end
        vectors++;
        if (ram_wdata !== exp_wdata) begin miscompares++; $display("FAIL ram_wdata cyc %0d: got %h expected %h", cyc, ram_wdata, exp_wdata); end
        vectors++;
        if (a_rvalid !== ev_a) begin miscompares++; $display("FAIL a_rvalid cyc %0d: got %b expected %b", cyc, a_rvalid, ev_a); end
        vectors++;
        if (b_rvalid !== ev_b) begin miscompares++; $display("FAIL b_rvalid cyc %0d: got %b expected %b", cyc, b_rvalid, ev_b); end
        if (ev_a) begin
            vectors++;
            if (a_rdata !== ev_d) begin miscompares++; $display("FAIL a_rdata cyc %0d: got %h expected %h", cyc, a_rdata, ev_d); end
        end
        if (ev_b) begin
            vectors++;
            if (b_rdata !== ev_d) begin miscompares++; $display("FAIL b_rdata cyc %0d: got %h expected %h", cyc, b_rdata, ev_d); end
        end

        // Transaction effect of this cycle's grant, as seen in following cycles
        if (eg_a || eg_b) begin
            exp_en    = 1'b1;
            exp_we    = eg_a ? aw : bw;
            exp_addr  = eg_a ? aa : ba;
            exp_wdata = eg_a ? ad : bd;
            if (exp_we) shadow[exp_addr] = exp_wdata;
            else        rq.push_back('{due: cyc + 2, owner: eg_b, data: shadow[exp_addr]});
            last_b = eg_b;
        end else begin
            exp_en = 1'b0;
            exp_we = 1'b0;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic test_reset();
        a_req = 1'b1; b_req = 1'b1;
        #1;
        vectors++;
        if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
            miscompares++; $display("FAIL reset_gnt: got %b%b expected 00", a_gnt, b_gnt);
        end
        vectors++;
        if ({ram_en, ram_we, ram_addr, ram_wdata} !== 18'h0) begin
            miscompares++; $display("FAIL reset_ram: got en=%b we=%b addr=%h wdata=%h expected all zero",
                                    ram_en, ram_we, ram_addr, ram_wdata);
        end
        vectors++;
        if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
            miscompares++; $display("FAIL reset_rvalid: got %b%b expected 00", a_rvalid, b_rvalid);
        end
        @(negedge clk);
        a_req = 1'b0; b_req = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
    endtask

    task automatic test_single_read();
        step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        idle(3);
    endtask

    task automatic test_contention();
        for (int i = 0; i < 8; i++)
            step(1, 1, 8'h20 + 8'(i), 8'hA0 + 8'(i), 1, 0, 8'h30 + 8'(i), 8'h00);
        step(0, 0, 8'h00, 8'h00, 1, 0, 8'h31, 8'h00);
        idle(3);
    endtask

    task automatic test_raw();
        step(1, 1, 8'h04, 8'h33, 0, 0, 8'h00, 8'h00);
        step(0, 0, 8'h00, 8'h00, 1, 0, 8'h04, 8'h00);
        idle(3);
    endtask

    task automatic test_reset_mid_read();
        step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (ram_en !== 1'b0) begin miscompares++; $display("FAIL midreset_ram_en: got %b expected 0", ram_en); end
        vectors++;
        if (a_gnt !== 1'b0) begin miscompares++; $display("FAIL midreset_a_gnt: got %b expected 0", a_gnt); end
        @(negedge clk);
        rst_n = 1'b1;
        a_req = 1'b0;
        model_reset();
        cyc += 2;
        idle(4);
    endtask

    task automatic test_idle();
        step(0, 0, 8'h00, 8'h00, 1, 1, 8'h77, 8'hC3);
        idle(5);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
        idle(3);
    endtask

    initial begin
        rst_n = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'(i * 7 + 3);
            shadow[i] = 8'(i * 7 + 3);
        end
        mem[8'h10]    = 8'h5A;
        shadow[8'h10] = 8'h5A;
        model_reset();
        @(posedge clk);
        test_reset();
        test_single_read();
        test_contention();
        test_raw();
        test_reset_mid_read();
        test_idle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
